// File: rtl/dma_addr_count_datapath.sv
// Per-channel base/current address and word-count registers of an 8237-style DMA controller, plus the stepped temp pair and terminal count.
// Latency: every strobe takes effect at the next posedge CLK; all outputs come straight from registers.
// Backpressure: none; strobes are accepted every cycle and conflicts are settled by a fixed priority.
//
// Ports:
//   CLK, RESET         clock; asynchronous active-low reset
//   prog_*             CPU byte writes into base+current regs (byte pointer selects low/high byte)
//   clr_byte_ptr       forces the byte pointer back to the low byte
//   active_ch          channel under service (from priority logic)
//   load_temp/step/writeback  service strobes from timing control
//   mode_addr_dec      per-channel address direction (1 = decrement)
//   mode_autoinit      per-channel reload-from-base after terminal count
//   status_clr         clears sticky tc_status
//   address_out, word_count_out  temp registers
//   tc                 one-cycle terminal-count pulse
//   tc_status          sticky per-channel terminal-count flags
// The byte-wide programming path assumes ADDR_W and CNT_W are both 16.
module dma_addr_count_datapath #(
  parameter  int NUM_CH = 4,
  parameter  int ADDR_W = 16,
  parameter  int CNT_W  = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              prog_we,
  input  logic [CH_W-1:0]   prog_ch,
  input  logic              prog_sel,
  input  logic [7:0]        prog_data,
  input  logic              clr_byte_ptr,
  input  logic [CH_W-1:0]   active_ch,
  input  logic              load_temp,
  input  logic              step,
  input  logic              writeback,
  input  logic [NUM_CH-1:0] mode_addr_dec,
  input  logic [NUM_CH-1:0] mode_autoinit,
  input  logic              status_clr,
  output logic [ADDR_W-1:0] address_out,
  output logic [CNT_W-1:0]  word_count_out,
  output logic              tc,
  output logic [NUM_CH-1:0] tc_status
);

  typedef enum logic {S_IDLE, S_LOADED} state_t;

  state_t            state;
  logic              byte_ptr;
  logic              tc_seen;
  logic [ADDR_W-1:0] temp_addr;
  logic [CNT_W-1:0]  temp_cnt;
  logic [ADDR_W-1:0] base_addr [NUM_CH];
  logic [CNT_W-1:0]  base_cnt  [NUM_CH];
  logic [ADDR_W-1:0] cur_addr  [NUM_CH];
  logic [CNT_W-1:0]  cur_cnt   [NUM_CH];

  logic              ptr_use;
  logic              do_step;
  logic              do_wb;
  logic              step_tc;
  logic              tc_seen_nxt;
  logic              reload;
  logic [ADDR_W-1:0] nxt_addr;
  logic [CNT_W-1:0]  nxt_cnt;
  logic [NUM_CH-1:0] set_mask;

  function automatic logic [ADDR_W-1:0] put_addr_byte(input logic [ADDR_W-1:0] v,
                                                      input logic hi, input logic [7:0] b);
    logic [ADDR_W-1:0] r;
    r = v;
    if (hi) r[15:8] = b;
    else    r[7:0]  = b;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] put_cnt_byte(input logic [CNT_W-1:0] v,
                                                    input logic hi, input logic [7:0] b);
    logic [CNT_W-1:0] r;
    r = v;
    if (hi) r[15:8] = b;
    else    r[7:0]  = b;
    return r;
  endfunction

  // A clear coinciding with a write makes that write land in the low byte.
  assign ptr_use = clr_byte_ptr ? 1'b0 : byte_ptr;

  // load_temp pre-empts step and writeback; both only mean something while a channel is loaded.
  assign do_step = step      && (state == S_LOADED) && !load_temp;
  assign do_wb   = writeback && (state == S_LOADED) && !load_temp;

  // Step is applied before writeback, so a coincident writeback stores the stepped values.
  assign nxt_addr = !do_step             ? temp_addr :
                    mode_addr_dec[active_ch] ? temp_addr - ADDR_W'(1) : temp_addr + ADDR_W'(1);
  assign nxt_cnt  = do_step ? temp_cnt - CNT_W'(1) : temp_cnt;

  assign step_tc     = do_step && (temp_cnt == '0);
  assign tc_seen_nxt = tc_seen || step_tc;
  assign reload      = tc_seen_nxt && mode_autoinit[active_ch];
  assign set_mask    = (do_wb && tc_seen_nxt) ? (NUM_CH'(1) << active_ch) : '0;

  assign address_out    = temp_addr;
  assign word_count_out = temp_cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_IDLE;
      byte_ptr  <= 1'b0;
      tc_seen   <= 1'b0;
      tc        <= 1'b0;
      tc_status <= '0;
      temp_addr <= '0;
      temp_cnt  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        base_addr[i] <= '0;
        base_cnt[i]  <= '0;
        cur_addr[i]  <= '0;
        cur_cnt[i]   <= '0;
      end
    end else begin
      if (prog_we) byte_ptr <= ~ptr_use;
      else         byte_ptr <= ptr_use;

      if (load_temp) begin
        state     <= S_LOADED;
        temp_addr <= cur_addr[active_ch];
        temp_cnt  <= cur_cnt[active_ch];
        tc_seen   <= 1'b0;
        tc        <= 1'b0;
      end else begin
        temp_addr <= nxt_addr;
        temp_cnt  <= nxt_cnt;
        tc        <= step_tc;
        tc_seen   <= do_wb ? 1'b0 : tc_seen_nxt;
        if (do_wb) state <= S_IDLE;
      end

      // Set beats clear when both land in the same cycle.
      tc_status <= (status_clr ? '0 : tc_status) | set_mask;

      // A CPU write to a register beats a writeback to that same register;
      // the other register of the channel still takes the writeback.
      for (int i = 0; i < NUM_CH; i++) begin
        if (prog_we && (prog_ch == CH_W'(i)) && !prog_sel) begin
          base_addr[i] <= put_addr_byte(base_addr[i], ptr_use, prog_data);
          cur_addr[i]  <= put_addr_byte(cur_addr[i], ptr_use, prog_data);
        end else if (do_wb && (active_ch == CH_W'(i))) begin
          cur_addr[i]  <= reload ? base_addr[i] : nxt_addr;
        end

        if (prog_we && (prog_ch == CH_W'(i)) && prog_sel) begin
          base_cnt[i] <= put_cnt_byte(base_cnt[i], ptr_use, prog_data);
          cur_cnt[i]  <= put_cnt_byte(cur_cnt[i], ptr_use, prog_data);
        end else if (do_wb && (active_ch == CH_W'(i))) begin
          cur_cnt[i]  <= reload ? base_cnt[i] : nxt_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_addr_count_datapath.sv
module tb_dma_addr_count_datapath;

  logic        CLK;
  logic        RESET;
  logic        prog_we;
  logic [1:0]  prog_ch;
  logic        prog_sel;
  logic [7:0]  prog_data;
  logic        clr_byte_ptr;
  logic [1:0]  active_ch;
  logic        load_temp;
  logic        step;
  logic        writeback;
  logic [3:0]  mode_addr_dec;
  logic [3:0]  mode_autoinit;
  logic        status_clr;
  logic [15:0] address_out;
  logic [15:0] word_count_out;
  logic        tc;
  logic [3:0]  tc_status;

  int checks = 0;
  int errors = 0;

  dma_addr_count_datapath #(.NUM_CH(4), .ADDR_W(16), .CNT_W(16)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .prog_we       (prog_we),
    .prog_ch       (prog_ch),
    .prog_sel      (prog_sel),
    .prog_data     (prog_data),
    .clr_byte_ptr  (clr_byte_ptr),
    .active_ch     (active_ch),
    .load_temp     (load_temp),
    .step          (step),
    .writeback     (writeback),
    .mode_addr_dec (mode_addr_dec),
    .mode_autoinit (mode_autoinit),
    .status_clr    (status_clr),
    .address_out   (address_out),
    .word_count_out(word_count_out),
    .tc            (tc),
    .tc_status     (tc_status)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [1:0]  pch;
    logic        sel;
    logic [7:0]  pd;
    logic        clr;
    logic [1:0]  ach;
    logic        ld;
    logic        st;
    logic        wb;
    logic        sclr;
    logic [15:0] ea;
    logic [15:0] ec;
    logic        etc;
    logic [3:0]  est;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] pch, input logic sel,
                              input logic [7:0] pd, input logic clr, input logic [1:0] ach,
                              input logic ld, input logic st, input logic wb, input logic sclr,
                              input logic [15:0] ea, input logic [15:0] ec,
                              input logic etc, input logic [3:0] est);
    vec_t v;
    v.we = we; v.pch = pch; v.sel = sel; v.pd = pd; v.clr = clr; v.ach = ach;
    v.ld = ld; v.st = st; v.wb = wb; v.sclr = sclr;
    v.ea = ea; v.ec = ec; v.etc = etc; v.est = est;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    prog_we = 0; prog_ch = 0; prog_sel = 0; prog_data = 0; clr_byte_ptr = 0;
    active_ch = 0; load_temp = 0; step = 0; writeback = 0; status_clr = 0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    @(negedge CLK);
    prog_we = v.we; prog_ch = v.pch; prog_sel = v.sel; prog_data = v.pd;
    clr_byte_ptr = v.clr; active_ch = v.ach; load_temp = v.ld; step = v.st;
    writeback = v.wb; status_clr = v.sclr;
    @(posedge CLK);
    #1;
    check({name, "_addr"}, 32'(address_out), 32'(v.ea));
    check({name, "_cnt"}, 32'(word_count_out), 32'(v.ec));
    check({name, "_tc"}, 32'(tc), 32'(v.etc));
    check({name, "_status"}, 32'(tc_status), 32'(v.est));
  endtask

  // Behavioural reference: registers as plain arrays, events applied in priority order.
  bit [15:0] mb_a [4];
  bit [15:0] mb_c [4];
  bit [15:0] mc_a [4];
  bit [15:0] mc_c [4];
  bit [15:0] mt_a, mt_c;
  bit        m_loaded, m_seen, m_tc, m_ptr;
  bit [3:0]  m_st;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mb_a[i] = 0; mb_c[i] = 0; mc_a[i] = 0; mc_c[i] = 0;
    end
    mt_a = 0; mt_c = 0; m_loaded = 0; m_seen = 0; m_tc = 0; m_ptr = 0; m_st = 0;
  endtask

  task automatic model_edge();
    int        ch, pc;
    bit        p, wbdone;
    bit [15:0] old_a, old_c;
    ch = int'(active_ch);
    pc = int'(prog_ch);
    p = clr_byte_ptr ? 1'b0 : m_ptr;
    wbdone = 0;
    m_tc = 0;
    old_a = mc_a[pc];
    old_c = mc_c[pc];
    if (load_temp) begin
      mt_a = mc_a[ch]; mt_c = mc_c[ch]; m_seen = 0; m_loaded = 1;
    end else if (m_loaded) begin
      if (step) begin
        if (mt_c == 0) begin m_tc = 1; m_seen = 1; end
        mt_a = 16'((int'(mt_a) + (mode_addr_dec[ch] ? 65535 : 1)) % 65536);
        mt_c = 16'((int'(mt_c) + 65535) % 65536);
      end
      if (writeback) begin wbdone = 1; m_loaded = 0; end
    end
    if (status_clr) m_st = 0;
    if (wbdone) begin
      if (m_seen && mode_autoinit[ch]) begin
        mc_a[ch] = mb_a[ch]; mc_c[ch] = mb_c[ch];
      end else begin
        mc_a[ch] = mt_a; mc_c[ch] = mt_c;
      end
      if (m_seen) m_st[ch] = 1;
      m_seen = 0;
    end
    if (prog_we) begin
      if (!prog_sel) begin
        if (p) begin mb_a[pc][15:8] = prog_data; old_a[15:8] = prog_data; end
        else   begin mb_a[pc][7:0]  = prog_data; old_a[7:0]  = prog_data; end
        mc_a[pc] = old_a;
      end else begin
        if (p) begin mb_c[pc][15:8] = prog_data; old_c[15:8] = prog_data; end
        else   begin mb_c[pc][7:0]  = prog_data; old_c[7:0]  = prog_data; end
        mc_c[pc] = old_c;
      end
      m_ptr = !p;
    end else begin
      m_ptr = p;
    end
  endtask

  vec_t tbl [21];

  initial begin
    // Programming ch0, a 3-transfer increment run to TC, then byte-pointer handling on ch3.
    tbl[0]  = mk(1, 0, 0, 8'h34, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 4'h0);
    tbl[1]  = mk(1, 0, 0, 8'h12, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 4'h0);
    tbl[2]  = mk(1, 0, 1, 8'h02, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 4'h0);
    tbl[3]  = mk(1, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 4'h0);
    tbl[4]  = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 16'h1234, 16'h0002, 0, 4'h0);
    tbl[5]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 16'h1235, 16'h0001, 0, 4'h0);
    tbl[6]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 16'h1236, 16'h0000, 0, 4'h0);
    tbl[7]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 16'h1237, 16'hFFFF, 1, 4'h0);
    tbl[8]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 16'h1237, 16'hFFFF, 0, 4'h0);
    tbl[9]  = mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 16'h1237, 16'hFFFF, 0, 4'h1);
    tbl[10] = mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 16'h1237, 16'hFFFF, 0, 4'h1);
    tbl[11] = mk(0, 0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 16'h1237, 16'hFFFF, 0, 4'h1);
    tbl[12] = mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 16'h1237, 16'hFFFF, 0, 4'h0);
    tbl[13] = mk(1, 3, 0, 8'hAA, 0, 0, 0, 0, 0, 0, 16'h1237, 16'hFFFF, 0, 4'h0);
    tbl[14] = mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 16'h1237, 16'hFFFF, 0, 4'h0);
    tbl[15] = mk(1, 3, 0, 8'h55, 0, 0, 0, 0, 0, 0, 16'h1237, 16'hFFFF, 0, 4'h0);
    tbl[16] = mk(1, 3, 0, 8'h66, 0, 0, 0, 0, 0, 0, 16'h1237, 16'hFFFF, 0, 4'h0);
    tbl[17] = mk(1, 3, 0, 8'h77, 0, 0, 0, 0, 0, 0, 16'h1237, 16'hFFFF, 0, 4'h0);
    tbl[18] = mk(1, 3, 0, 8'h88, 1, 0, 0, 0, 0, 0, 16'h1237, 16'hFFFF, 0, 4'h0);
    tbl[19] = mk(1, 3, 0, 8'h99, 0, 0, 0, 0, 0, 0, 16'h1237, 16'hFFFF, 0, 4'h0);
    tbl[20] = mk(0, 0, 0, 8'h00, 0, 3, 1, 0, 0, 0, 16'h9988, 16'h0000, 0, 4'h0);

    idle_inputs();
    mode_addr_dec = 4'b0000;
    mode_autoinit = 4'b0000;
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_addr", 32'(address_out), 32'h0);
    check("reset_cnt", 32'(word_count_out), 32'h0);
    check("reset_tc", 32'(tc), 32'h0);
    check("reset_status", 32'(tc_status), 32'h0);
    @(negedge CLK);
    RESET = 1'b1;

    for (int i = 0; i < 21; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // ch1 decrement + autoinit from 0/0: wrap to 0xFFFF with TC, base restored on writeback.
    mode_addr_dec = 4'b0010;
    mode_autoinit = 4'b0010;
    run_vec(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 4'h0), "ai_load");
    run_vec(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 16'hFFFF, 16'hFFFF, 1, 4'h0), "ai_step");
    run_vec(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 4'h0), "ai_gap");
    run_vec(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 16'hFFFF, 16'hFFFF, 0, 4'h2), "ai_wb");
    run_vec(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 4'h2), "ai_reload");
    run_vec(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 4'h0), "ai_sclr");
    // step + writeback + status_clr together: TC from that step counts, set beats clear.
    run_vec(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 16'hFFFF, 16'hFFFF, 1, 4'h2), "ai_stwb");
    run_vec(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 4'h2), "ai_reload2");

    // ch2: CPU write to the address register coinciding with writeback wins.
    run_vec(mk(0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 4'h2), "pw_clr");
    run_vec(mk(1, 2, 0, 8'h00, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 4'h2), "pw_a0");
    run_vec(mk(1, 2, 0, 8'h50, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 4'h2), "pw_a1");
    run_vec(mk(1, 2, 1, 8'h05, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 4'h2), "pw_c0");
    run_vec(mk(1, 2, 1, 8'h00, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 4'h2), "pw_c1");
    run_vec(mk(0, 0, 0, 8'h00, 0, 2, 1, 0, 0, 0, 16'h5000, 16'h0005, 0, 4'h2), "pw_load");
    run_vec(mk(0, 0, 0, 8'h00, 0, 2, 0, 1, 0, 0, 16'h5001, 16'h0004, 0, 4'h2), "pw_step1");
    run_vec(mk(0, 0, 0, 8'h00, 0, 2, 0, 1, 0, 0, 16'h5002, 16'h0003, 0, 4'h2), "pw_step2");
    run_vec(mk(1, 2, 0, 8'h77, 0, 2, 0, 0, 1, 0, 16'h5002, 16'h0003, 0, 4'h2), "pw_wb");
    run_vec(mk(0, 0, 0, 8'h00, 0, 2, 1, 0, 0, 0, 16'h5077, 16'h0003, 0, 4'h2), "pw_reload");

    // Asynchronous reset in the middle of service.
    run_vec(mk(0, 0, 0, 8'h00, 0, 2, 0, 1, 0, 0, 16'h5078, 16'h0002, 0, 4'h2), "ar_step");
    #2;
    RESET = 1'b0;
    #1;
    check("ar_addr", 32'(address_out), 32'h0);
    check("ar_cnt", 32'(word_count_out), 32'h0);
    check("ar_tc", 32'(tc), 32'h0);
    check("ar_status", 32'(tc_status), 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    run_vec(mk(0, 0, 0, 8'h00, 0, 2, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 4'h0), "ar_idle_step");

    // Randomized traffic against the reference model.
    for (int seg = 0; seg < 2; seg++) begin
      @(negedge CLK);
      idle_inputs();
      mode_addr_dec = 4'($urandom);
      mode_autoinit = 4'($urandom);
      RESET = 1'b0;
      model_reset();
      @(negedge CLK);
      RESET = 1'b1;
      for (int n = 0; n < 400; n++) begin
        @(negedge CLK);
        prog_we      = ($urandom_range(0, 3) == 0);
        prog_ch      = 2'($urandom_range(0, 3));
        prog_sel     = 1'($urandom_range(0, 1));
        prog_data    = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
        clr_byte_ptr = ($urandom_range(0, 9) == 0);
        active_ch    = 2'($urandom_range(0, 3));
        load_temp    = ($urandom_range(0, 7) == 0);
        step         = ($urandom_range(0, 1) == 1);
        writeback    = ($urandom_range(0, 7) == 0);
        status_clr   = ($urandom_range(0, 15) == 0);
        model_edge();
        @(posedge CLK);
        #1;
        check("rnd_addr", 32'(address_out), 32'(mt_a));
        check("rnd_cnt", 32'(word_count_out), 32'(mt_c));
        check("rnd_tc", 32'(tc), 32'(m_tc));
        check("rnd_status", 32'(tc_status), 32'(m_st));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
